dc_fwd_unit: RTL and testbench

Parametrised dependency-check and forwarding-control unit for the MIPS pipeline. It sits between fetch and execute. Per accepted instruction it produces:
- registered decode fields;
- operand-A/B forwarding selects over a configurable window of older in-flight instructions;
- a load-use stall with bubble insertion, which the current dependency-check logic cannot produce.

---
 rtl/dc_fwd_unit_if.sv | 29 ++
 rtl/dc_fwd_unit.sv | 125 ++++++++++++
 tb/tb_dc_fwd_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dc_fwd_unit_if.sv
// Fetch-to-execute bus of the dependency-check / forwarding unit.
// The master drives instructions; the slave returns stall and the decode/forwarding controls.
interface dc_fwd_unit_if;
    logic [31:0] ins;
    logic        ins_valid;
    logic        stall;
    logic [5:0]  op_dec;
    logic [15:0] imm;
    logic        imm_sel;
    logic [1:0]  mux_sel_A;
    logic [1:0]  mux_sel_B;
    logic        mem_en_ex;
    logic        mem_rw_ex;
    logic        mem_mux_sel_dm;
    logic [4:0]  RW_dm;
    logic        wr_en_dm;

    modport master (
        output ins, ins_valid,
        input  stall, op_dec, imm, imm_sel, mux_sel_A, mux_sel_B,
               mem_en_ex, mem_rw_ex, mem_mux_sel_dm, RW_dm, wr_en_dm
    );

    modport slave (
        input  ins, ins_valid,
        output stall, op_dec, imm, imm_sel, mux_sel_A, mux_sel_B,
               mem_en_ex, mem_rw_ex, mem_mux_sel_dm, RW_dm, wr_en_dm
    );
endinterface

// File: rtl/dc_fwd_unit.sv
// Decode, operand forwarding selects and load-use stall for the MIPS pipeline.
// A DEPTH-entry history of recently accepted instructions drives all hazard decisions.
module dc_fwd_unit #(
    parameter int         DEPTH  = 2,
    parameter logic [5:0] NOP_OP = 6'b111111
) (
    input logic          clk,
    input logic          reset,
    dc_fwd_unit_if.slave bus
);
    typedef struct packed {
        logic       wr;
        logic       ld;
        logic [4:0] rd;
    } hist_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [15:0] imm;
        logic        imm_sel;
        logic [1:0]  sel_a;
        logic [1:0]  sel_b;
        logic        mem_en;
        logic        mem_rw;
    } ex_t;

    localparam ex_t EX_BUBBLE = '{NOP_OP, 16'h0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};

    hist_t hist_q [DEPTH];
    hist_t hist_new;
    hist_t dm_q;
    ex_t   ex_q, ex_d;

    logic [5:0] op;
    logic [4:0] rd, rs1, rs2, src_b;
    logic       reads_a, reads_b, writes, is_load, imm_sel, mem_en, mem_rw;
    logic [1:0] sel_a, sel_b;
    logic       stall, accept;

    assign op  = bus.ins[31:26];
    assign rd  = bus.ins[25:21];
    assign rs1 = bus.ins[20:16];
    assign rs2 = bus.ins[15:11];

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin : decode
        reads_a = 1'b0;
        reads_b = 1'b0;
        src_b   = rs2;
        writes  = 1'b0;
        is_load = 1'b0;
        imm_sel = 1'b0;
        mem_en  = 1'b0;
        mem_rw  = 1'b0;
        if (op != NOP_OP) begin
            reads_a = 1'b1;
            case (op[5:3])
                3'b000: begin reads_b = 1'b1; writes = 1'b1; end
                3'b001: begin writes = 1'b1; imm_sel = 1'b1; end
                3'b010: begin writes = 1'b1; imm_sel = 1'b1; is_load = 1'b1; mem_en = 1'b1; end
                3'b011: begin reads_b = 1'b1; src_b = rd; mem_en = 1'b1; mem_rw = 1'b1; end
                default: reads_b = 1'b1;
            endcase
        end
    end

    // Scan oldest to youngest so the youngest matching writer overrides.
    always_comb begin : fwd_select
        sel_a = 2'd0;
        sel_b = 2'd0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hist_q[k].wr && hist_q[k].rd != 5'd0) begin
                if (hist_q[k].rd == rs1)   sel_a = 2'(k + 1);
                if (hist_q[k].rd == src_b) sel_b = 2'(k + 1);
            end
        end
    end

    // A load one slot back cannot forward yet; hold the reader for one cycle.
    assign stall  = bus.ins_valid && hist_q[0].ld &&
                    ((reads_a && sel_a == 2'd1) || (reads_b && sel_b == 2'd1));
    assign accept = bus.ins_valid && !stall;

    always_comb begin : next_state
        ex_d     = EX_BUBBLE;
        hist_new = '0;
        if (accept) begin
            ex_d.op      = op;
            ex_d.imm     = bus.ins[15:0];
            ex_d.imm_sel = imm_sel;
            ex_d.sel_a   = reads_a ? sel_a : 2'd0;
            ex_d.sel_b   = reads_b ? sel_b : 2'd0;
            ex_d.mem_en  = mem_en;
            ex_d.mem_rw  = mem_rw;
            hist_new     = '{wr: writes, ld: is_load, rd: rd};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q <= EX_BUBBLE;
            dm_q <= '0;
            // NOTE: the history is tiny and must be cleared so nothing forwards from before reset.
            for (int k = 0; k < DEPTH; k++) hist_q[k] <= '0;
        end else begin
            ex_q      <= ex_d;
            dm_q      <= hist_q[0];
            hist_q[0] <= hist_new;
            for (int k = 1; k < DEPTH; k++) hist_q[k] <= hist_q[k-1];
        end
    end

    assign bus.stall          = stall;
    assign bus.op_dec         = ex_q.op;
    assign bus.imm            = ex_q.imm;
    assign bus.imm_sel        = ex_q.imm_sel;
    assign bus.mux_sel_A      = ex_q.sel_a;
    assign bus.mux_sel_B      = ex_q.sel_b;
    assign bus.mem_en_ex      = ex_q.mem_en;
    assign bus.mem_rw_ex      = ex_q.mem_rw;
    assign bus.RW_dm          = dm_q.rd;
    assign bus.wr_en_dm       = dm_q.wr;
    assign bus.mem_mux_sel_dm = dm_q.ld;
endmodule

// File: tb/tb_dc_fwd_unit.sv
// Scoreboard bench: DEPTH=1,2,3 instances share one instruction stream and are checked
// against an instruction-level reference model of the hazard rules.
module tb_dc_fwd_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ins_r = '0;
    logic        valid_r = 1'b0;

    always #5 clk = ~clk;

    dc_fwd_unit_if if1 ();
    dc_fwd_unit_if if2 ();
    dc_fwd_unit_if if3 ();

    assign if1.ins = ins_r;  assign if1.ins_valid = valid_r;
    assign if2.ins = ins_r;  assign if2.ins_valid = valid_r;
    assign if3.ins = ins_r;  assign if3.ins_valid = valid_r;

    dc_fwd_unit #(.DEPTH(1)) u_d1 (.clk(clk), .reset(reset), .bus(if1.slave));
    dc_fwd_unit #(.DEPTH(2)) u_d2 (.clk(clk), .reset(reset), .bus(if2.slave));
    dc_fwd_unit #(.DEPTH(3)) u_d3 (.clk(clk), .reset(reset), .bus(if3.slave));

    typedef struct {
        logic       wr;
        logic       ld;
        logic [4:0] rd;
    } slot_t;

    typedef struct packed {
        logic            stall;
        logic [5:0]      op;
        logic [15:0]     imm;
        logic            imm_sel;
        logic [2:0][1:0] sel_a;
        logic [2:0][1:0] sel_b;
        logic            men;
        logic            mrw;
        logic            dm_wr;
        logic [4:0]      dm_rd;
        logic            dm_msel;
    } exp_t;

    typedef struct packed {
        logic        stall;
        logic [5:0]  op;
        logic [15:0] imm;
        logic        imm_sel;
        logic [1:0]  sel_a;
        logic [1:0]  sel_b;
        logic        men;
        logic        mrw;
        logic        msel;
        logic [4:0]  rw;
        logic        wr;
    } obs_t;

    slot_t slots [$];
    exp_t  exp_q [$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s depth=%0d actual=%0h required=%0h t=%0t", name, d + 1, act, exp, $time);
        end
    endtask

    function automatic obs_t sample(int d);
        obs_t o;
        case (d)
            0: o = {if1.stall, if1.op_dec, if1.imm, if1.imm_sel, if1.mux_sel_A, if1.mux_sel_B,
                    if1.mem_en_ex, if1.mem_rw_ex, if1.mem_mux_sel_dm, if1.RW_dm, if1.wr_en_dm};
            1: o = {if2.stall, if2.op_dec, if2.imm, if2.imm_sel, if2.mux_sel_A, if2.mux_sel_B,
                    if2.mem_en_ex, if2.mem_rw_ex, if2.mem_mux_sel_dm, if2.RW_dm, if2.wr_en_dm};
            default: o = {if3.stall, if3.op_dec, if3.imm, if3.imm_sel, if3.mux_sel_A, if3.mux_sel_B,
                    if3.mem_en_ex, if3.mem_rw_ex, if3.mem_mux_sel_dm, if3.RW_dm, if3.wr_en_dm};
        endcase
        return o;
    endfunction

    function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rd, logic [4:0] rs1,
                                       logic [4:0] rs2, logic [10:0] lo = 11'h0);
        return {op, rd, rs1, rs2, lo};
    endfunction

    // Youngest in-flight writer of src within the last `depth` slots, 0 if none.
    function automatic int find(logic [4:0] src, int depth);
        for (int k = 0; k < depth && k < slots.size(); k++)
            if (slots[k].wr && src != 5'd0 && slots[k].rd == src) return k + 1;
        return 0;
    endfunction

    task automatic model_step(input logic [31:0] i, input logic v, output logic st);
        exp_t        e;
        slot_t       s, prev;
        logic [5:0]  op;
        logic [2:0]  cls;
        logic        nop, ra, rb, w, ld, isel, men, mrw;
        logic [4:0]  sa, sb;
        op   = i[31:26];
        cls  = op[5:3];
        nop  = (op == 6'h3f);
        ra   = !nop;
        rb   = !nop && (cls == 3'd0 || cls == 3'd3 || cls >= 3'd4);
        sa   = i[20:16];
        sb   = (cls == 3'd3) ? i[25:21] : i[15:11];
        w    = !nop && cls <= 3'd2;
        ld   = cls == 3'd2;
        isel = cls == 3'd1 || cls == 3'd2;
        men  = cls == 3'd2 || cls == 3'd3;
        mrw  = cls == 3'd3;
        prev = (slots.size() > 0) ? slots[0] : '{1'b0, 1'b0, 5'd0};
        st   = v && prev.ld && ((ra && find(sa, 1) == 1) || (rb && find(sb, 1) == 1));
        e         = '0;
        e.op      = 6'h3f;
        e.stall   = st;
        e.dm_wr   = prev.wr;
        e.dm_rd   = prev.rd;
        e.dm_msel = prev.ld;
        s = '{1'b0, 1'b0, 5'd0};
        if (v && !st) begin
            e.op      = op;
            e.imm     = i[15:0];
            e.imm_sel = isel;
            e.men     = men;
            e.mrw     = mrw;
            for (int d = 0; d < 3; d++) begin
                e.sel_a[d] = ra ? 2'(find(sa, d + 1)) : 2'd0;
                e.sel_b[d] = rb ? 2'(find(sb, d + 1)) : 2'd0;
            end
            s = '{w, ld, i[25:21]};
        end
        slots.push_front(s);
        if (slots.size() > 3) void'(slots.pop_back());
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic [31:0] i, input logic v, output logic st);
        @(negedge clk);
        ins_r   = i;
        valid_r = v;
        #1;
        model_step(i, v, st);
    endtask

    // Upstream behaviour: hold the instruction while the model says it stalls.
    task automatic issue(input logic [31:0] i);
        logic st;
        for (int n = 0; n < 4; n++) begin
            cycle(i, 1'b1, st);
            if (!st) break;
        end
    endtask

    task automatic check_reset_values(input string tag);
        obs_t o;
        for (int d = 0; d < 3; d++) begin
            o = sample(d);
            check({tag, "_stall"}, d, 32'(o.stall), 32'd0);
            check({tag, "_op"}, d, 32'(o.op), 32'h3f);
            check({tag, "_rest"}, d, 32'({o.imm, o.imm_sel, o.sel_a, o.sel_b, o.men, o.mrw,
                                          o.msel, o.rw, o.wr}), 32'd0);
        end
    endtask

    // Monitor: stall is compared mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        obs_t o;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int d = 0; d < 3; d++) begin
                    o = sample(d);
                    check("stall", d, 32'(o.stall), 32'(e.stall));
                end
                @(posedge clk);
                #1;
                for (int d = 0; d < 3; d++) begin
                    o = sample(d);
                    check("op_dec", d, 32'(o.op), 32'(e.op));
                    check("imm", d, 32'(o.imm), 32'(e.imm));
                    check("imm_sel", d, 32'(o.imm_sel), 32'(e.imm_sel));
                    check("mux_sel_A", d, 32'(o.sel_a), 32'(e.sel_a[d]));
                    check("mux_sel_B", d, 32'(o.sel_b), 32'(e.sel_b[d]));
                    check("mem_en_ex", d, 32'(o.men), 32'(e.men));
                    check("mem_rw_ex", d, 32'(o.mrw), 32'(e.mrw));
                    check("wr_en_dm", d, 32'(o.wr), 32'(e.dm_wr));
                    check("mem_mux_sel_dm", d, 32'(o.msel), 32'(e.dm_msel));
                    if (e.dm_wr) check("RW_dm", d, 32'(o.rw), 32'(e.dm_rd));
                end
            end
        end
    end

    initial begin
        logic        st;
        logic [31:0] ri;
        logic [5:0]  rop;

        #12;
        check_reset_values("reset");
        @(negedge clk);
        #1 reset = 1'b1;

        // ALU chain
        issue(mk(6'b000000, 5'd3, 5'd1, 5'd2));
        issue(mk(6'b000000, 5'd4, 5'd3, 5'd1));
        // Two-back forward
        issue(mk(6'b000000, 5'd3, 5'd1, 5'd2));
        issue(mk(6'b000001, 5'd7, 5'd10, 5'd11));
        issue(mk(6'b000000, 5'd8, 5'd9, 5'd3));
        // Load-use
        issue(mk(6'b010100, 5'd4, 5'd1, 5'd0, 11'h123));
        issue(mk(6'b000100, 5'd5, 5'd4, 5'd4));
        // Youngest wins, r0 never forwards
        issue(mk(6'b000000, 5'd5, 5'd1, 5'd2));
        issue(mk(6'b001000, 5'd5, 5'd2, 5'd0, 11'h0aa));
        issue(mk(6'b000000, 5'd6, 5'd5, 5'd5));
        issue(mk(6'b000000, 5'd0, 5'd1, 5'd2));
        issue(mk(6'b001000, 5'd0, 5'd1, 5'd2));
        issue(mk(6'b000000, 5'd9, 5'd0, 5'd0));
        // Store data hazard
        issue(mk(6'b000000, 5'd6, 5'd1, 5'd2));
        issue(mk(6'b011000, 5'd6, 5'd1, 5'd0, 11'h044));
        cycle(32'h0, 1'b0, st);
        cycle(32'h0, 1'b0, st);

        // Reset during a load-use stall
        issue(mk(6'b010000, 5'd4, 5'd1, 5'd0));
        @(negedge clk);
        ins_r   = mk(6'b000100, 5'd5, 5'd4, 5'd4);
        valid_r = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) check("stall_pre_reset", d, 32'(sample(d).stall), 32'd1);
        #1 reset = 1'b0;
        #1;
        check_reset_values("mid_reset");
        slots.delete();
        valid_r = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        issue(mk(6'b000100, 5'd5, 5'd4, 5'd4));

        // Randomized stream over a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            rop = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 9) == 0) rop = 6'h3f;
            ri = mk(rop, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 11'($urandom));
            if ($urandom_range(0, 4) != 0) issue(ri);
            else cycle(ri, 1'b0, st);
        end

        repeat (3) cycle(32'h0, 1'b0, st);
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drain", 0, 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
